// File: rtl/mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mmio_initiator
// Brief    : Turns a valid/ready command stream into single-cycle MMIO write
//            and read request pulses, tracks outstanding reads in order,
//            matches read responses by tid and retires silent reads by timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_initiator #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // command stream
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_write,
    input  logic [15:0]                            cmd_addr,
    input  logic [63:0]                            cmd_wdata,
    // MMIO request channel towards the AFU
    output logic                                   mmio_wr_valid,
    output logic                                   mmio_rd_valid,
    output logic [15:0]                            mmio_address,
    output logic [8:0]                             mmio_tid,
    output logic [63:0]                            mmio_data,
    // read responses from the AFU
    input  logic                                   rsp_in_valid,
    input  logic [8:0]                             rsp_in_tid,
    input  logic [63:0]                            rsp_in_data,
    // read completions
    output logic                                   rd_valid,
    output logic [15:0]                            rd_addr,
    output logic [63:0]                            rd_data,
    output logic                                   rd_timeout,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_tid
);

    localparam int               PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int               CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [63:0]      TMO_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    // In-order read tracking queue (tid + address per entry)
    logic [8:0]       tid_q  [MAX_OUTSTANDING];
    logic [15:0]      addr_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [8:0]       tid_ctr;
    logic [TMR_W-1:0] head_timer;

    logic             accept;
    logic             push;
    logic             q_empty;
    logic [8:0]       head_tid;
    logic [15:0]      head_addr;
    logic             rsp_match;
    logic             rsp_miss;
    logic             timeout_hit;
    logic             pop;

    // The outstanding counter doubles as the queue occupancy, so ready is
    // purely a function of registered state.
    assign cmd_ready   = (outstanding < DEPTH);
    assign accept      = cmd_valid && cmd_ready;
    assign push        = accept && !cmd_write;
    assign q_empty     = (outstanding == '0);
    assign head_tid    = tid_q[rd_ptr];
    assign head_addr   = addr_q[rd_ptr];

    // A matching response always wins over a timeout in the same cycle.
    assign rsp_match   = rsp_in_valid && !q_empty && (rsp_in_tid == head_tid);
    assign rsp_miss    = rsp_in_valid && !rsp_match;
    assign timeout_hit = !q_empty && !rsp_match && (head_timer == TMO_LAST);
    assign pop         = rsp_match || timeout_hit;

    // Queue payload storage; only written on a read accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            tid_q[wr_ptr]  <= tid_ctr;
            addr_q[wr_ptr] <= cmd_addr;
        end
    end

    // Queue pointers, occupancy, tid allocation and head-of-queue timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            tid_ctr     <= '0;
            head_timer  <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tid_ctr <= tid_ctr + 9'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
            // Timer restarts whenever a new entry becomes head: after a pop,
            // or when pushing into an empty queue (occupancy was zero).
            if (pop || q_empty) begin
                head_timer <= '0;
            end else begin
                head_timer <= head_timer + TMR_W'(1);
            end
        end
    end

    // Registered MMIO request pulses; fields are zero when no request is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_address  <= '0;
            mmio_tid      <= '0;
            mmio_data     <= '0;
        end else begin
            mmio_wr_valid <= accept && cmd_write;
            mmio_rd_valid <= push;
            mmio_address  <= accept ? cmd_addr : 16'd0;
            mmio_tid      <= push ? tid_ctr : 9'd0;
            mmio_data     <= (accept && cmd_write) ? cmd_wdata : 64'd0;
        end
    end

    // Registered read completions plus the sticky unmatched-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
            rd_timeout <= 1'b0;
            err_tid    <= 1'b0;
        end else begin
            rd_valid   <= pop;
            rd_addr    <= pop ? head_addr : 16'd0;
            rd_timeout <= timeout_hit;
            if (rsp_match) begin
                rd_data <= rsp_in_data;
            end else if (timeout_hit) begin
                rd_data <= TMO_DATA;
            end else begin
                rd_data <= 64'd0;
            end
            if (rsp_miss) begin
                err_tid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_initiator
// Brief    : Scoreboard bench for mmio_initiator: stimulus pushes expected
//            requests/completions, a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_initiator;

    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_address;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_data;
    logic        rsp_in_valid = 1'b0;
    logic [8:0]  rsp_in_tid = '0;
    logic [63:0] rsp_in_data = '0;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_timeout;
    logic [2:0]  outstanding;
    logic        err_tid;

    mmio_initiator #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_address(mmio_address), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
        .rsp_in_valid(rsp_in_valid), .rsp_in_tid(rsp_in_tid), .rsp_in_data(rsp_in_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_timeout(rd_timeout), .outstanding(outstanding), .err_tid(err_tid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic wr; logic [15:0] addr; logic [8:0] tid; logic [63:0] data; } req_t;
    typedef struct packed { logic [15:0] addr; logic [63:0] data; logic tmo; } cpl_t;
    typedef struct packed { logic [8:0] tid; logic [15:0] addr; } ent_t;
    typedef struct packed { logic [8:0] tid; logic [15:0] addr; logic [63:0] data; logic want; } rsp_t;

    req_t        req_q[$];
    cpl_t        cpl_q[$];
    ent_t        model_q[$];
    rsp_t        man_q[$];
    logic [8:0]  model_tid = '0;
    bit          auto_en = 1'b0;
    int unsigned acc_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] rsp_data(input logic [15:0] a);
        return {16'hC0DE, a, 16'h5A5A, ~a};
    endfunction

    // Monitor: every request pulse and every completion must match the next expectation.
    always @(negedge clk) begin
        req_t got_r, exp_r;
        cpl_t got_c, exp_c;
        if (mmio_wr_valid && mmio_rd_valid) check("req_exclusive", 128'(1), 128'(0));
        if (mmio_wr_valid || mmio_rd_valid) begin
            got_r = req_t'{mmio_wr_valid, mmio_address, mmio_tid, mmio_data};
            if (req_q.size() == 0) check("req_unexpected", 128'(got_r), 128'(0) - 128'(1));
            else begin
                exp_r = req_q.pop_front();
                check("req", 128'(got_r), 128'(exp_r));
            end
        end
        if (rd_valid) begin
            got_c = cpl_t'{rd_addr, rd_data, rd_timeout};
            if (cpl_q.size() == 0) check("cpl_unexpected", 128'(got_c), 128'(0) - 128'(1));
            else begin
                exp_c = cpl_q.pop_front();
                check("cpl", 128'(got_c), 128'(exp_c));
            end
        end
    end

    // Responder: auto mode answers each read pulse at once; manual items are replayed as queued.
    always @(negedge clk) begin
        ent_t e;
        rsp_t r;
        rsp_in_valid = 1'b0;
        rsp_in_tid   = '0;
        rsp_in_data  = '0;
        if (auto_en && mmio_rd_valid && model_q.size() > 0) begin
            e = model_q.pop_front();
            rsp_in_valid = 1'b1;
            rsp_in_tid   = e.tid;
            rsp_in_data  = rsp_data(e.addr);
            cpl_q.push_back(cpl_t'{e.addr, rsp_data(e.addr), 1'b0});
        end else if (man_q.size() > 0) begin
            r = man_q.pop_front();
            rsp_in_valid = 1'b1;
            rsp_in_tid   = r.tid;
            rsp_in_data  = r.data;
            if (r.want) cpl_q.push_back(cpl_t'{r.addr, r.data, 1'b0});
        end
    end

    task automatic issue(input logic wr, input logic [15:0] a, input logic [63:0] d);
        bit ok;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            ok = cmd_ready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_bound", 128'(0), 128'(1));
            cmd_valid = 1'b0;
            return;
        end
        #1 acc_cyc = cyc;
        if (wr) req_q.push_back(req_t'{1'b1, a, 9'd0, d});
        else begin
            req_q.push_back(req_t'{1'b0, a, model_tid, 64'd0});
            model_q.push_back(ent_t'{model_tid, a});
            model_tid = model_tid + 9'd1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cpl(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_valid) begin seen = 1'b1; break; end
        end
        if (!seen) check(name, 128'(0), 128'(1));
    endtask

    task automatic wait_drain(input string name, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (req_q.size() == 0 && cpl_q.size() == 0 && outstanding == 3'd0) begin
                done = 1'b1; break;
            end
        end
        if (!done) check(name, 128'(0), 128'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 128'({mmio_wr_valid, mmio_rd_valid, mmio_address, mmio_tid, mmio_data}), 128'(0));
        check({tag, "_cpl"}, 128'({rd_valid, rd_addr, rd_data, rd_timeout}), 128'(0));
        check({tag, "_outstanding"}, 128'(outstanding), 128'(0));
        check({tag, "_err_tid"}, 128'(err_tid), 128'(0));
        check({tag, "_ready"}, 128'(cmd_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ent_t e;
        // power-on reset
        #1 rst = 1'b1;
        #1 check_reset_state("reset_por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // write: one pulse with address, data, tid 0
        issue(1'b1, 16'h0020, 64'hDEAD_BEEF_0123_4567);
        idle();
        @(negedge clk);
        check("write_single_pulse", 128'({mmio_wr_valid, mmio_rd_valid}), 128'(0));
        check("write_no_outstanding", 128'(outstanding), 128'(0));

        // back-to-back reads against the 1-cycle responder
        auto_en = 1'b1;
        issue(1'b0, 16'h0000, 64'd0);
        issue(1'b0, 16'h0020, 64'd0);
        idle();
        wait_drain("read_drain", 30);
        check("read_outstanding", 128'(outstanding), 128'(0));
        check("read_err_tid", 128'(err_tid), 128'(0));

        // timeout on a silent read (tid 2), then a late response
        auto_en = 1'b0;
        issue(1'b0, 16'h0040, 64'd0);
        cpl_q.push_back(cpl_t'{16'h0040, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        idle();
        void'(model_q.pop_front());
        wait_cpl("timeout_bound");
        check("timeout_latency", 128'(cyc - acc_cyc), 128'(8));
        @(posedge clk); #1;
        man_q.push_back(rsp_t'{9'd2, 16'h0040, 64'h1111, 1'b0});
        repeat (3) @(negedge clk);
        check("late_rsp_err_tid", 128'(err_tid), 128'(1));
        check("late_rsp_outstanding", 128'(outstanding), 128'(0));

        // flow control: four silent reads fill the queue (tids 3..6)
        for (int i = 0; i < 4; i++) issue(1'b0, 16'h0100 + 16'(i), 64'd0);
        idle();
        check("full_ready", 128'(cmd_ready), 128'(0));
        check("full_outstanding", 128'(outstanding), 128'(4));
        @(negedge clk);
        check("full_ready_hold", 128'(cmd_ready), 128'(0));
        @(posedge clk); #1;
        e = model_q.pop_front();
        man_q.push_back(rsp_t'{9'd3, 16'h0100, rsp_data(16'h0100), 1'b1});
        wait_cpl("flow_cpl1_bound");
        check("flow_ready_after_pop", 128'(cmd_ready), 128'(1));
        check("flow_outstanding_3", 128'(outstanding), 128'(3));
        @(posedge clk); #1;
        e = model_q.pop_front();
        man_q.push_back(rsp_t'{9'd4, 16'h0101, rsp_data(16'h0101), 1'b1});
        wait_cpl("flow_cpl2_bound");
        check("flow_outstanding_2", 128'(outstanding), 128'(2));

        // reset with two reads outstanding
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_state("reset_mid");
        model_q.delete();
        model_tid = 9'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        auto_en = 1'b1;
        issue(1'b0, 16'h0008, 64'd0);   // expected tid 0
        idle();
        wait_drain("post_reset_drain", 30);

        // tid wrap: tids 1..513 mod 512 pass through 511, 0, 1
        for (int i = 0; i < 513; i++) issue(1'b0, 16'(i * 8), 64'd0);
        idle();
        wait_drain("wrap_drain", 50);
        check("wrap_err_tid", 128'(err_tid), 128'(0));
        check("wrap_next_tid_model", 128'(model_tid), 128'(9'd2));

        // stale response into an empty queue after reset
        auto_en = 1'b0;
        @(posedge clk); #1;
        man_q.push_back(rsp_t'{9'h155, 16'h0000, 64'h0, 1'b0});
        repeat (3) @(negedge clk);
        check("stale_err_tid", 128'(err_tid), 128'(1));
        check("leftover_expectations", 128'(req_q.size() + cpl_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_initiator.md
# mmio_initiator

Synthesizable MMIO request initiator that drives the host-to-AFU MMIO request channel (CCI-P Rx c0 MMIO fields) and consumes the AFU's read responses (CCI-P Tx c2). It turns a simple valid/ready command stream into single-cycle MMIO write and read request pulses. It allocates transaction IDs, tracks outstanding reads in order, matches responses by tid, and times out reads that receive no response. Its first use is as the on-chip stimulus source for AFU bring-up and loopback self-test.

## Interface
- MAX_OUTSTANDING, 4: read-tracking queue depth; power of 2, minimum 2.
- TIMEOUT, 256: cycles a head read may wait before it is retired as a timeout; minimum 4.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = MMIO write, 0 = MMIO read.
- cmd_addr  in  16  MMIO address (the AFU's address units).
- cmd_wdata  in  64  write data; ignored for reads.
- mmio_wr_valid  out  1  write request pulse (to rx.c0.mmioWrValid).
- mmio_rd_valid  out  1  read request pulse (to rx.c0.mmioRdValid).
- mmio_address  out  16  request address (to the c0 MMIO header address field).
- mmio_tid  out  9  request tid (to the c0 MMIO header tid field).
- mmio_data  out  64  write data (to rx.c0.data).
- rsp_in_valid  in  1  AFU read response valid (tx.c2.mmioRdValid).
- rsp_in_tid  in  9  response tid (tx.c2.hdr.tid).
- rsp_in_data  in  64  response data (tx.c2.data).
- rd_valid  out  1  read completion pulse.
- rd_addr  out  16  address of the completed read.
- rd_data  out  64  read data; all ones on timeout.
- rd_timeout  out  1  qualifies rd_valid; 1 = completion produced by timeout.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of reads in flight.
- err_tid  out  1  sticky; set by any unmatched response.

## Operation
- cmd_ready is 1 when outstanding < MAX_OUTSTANDING, for both command types. At most one command is accepted per cycle.
- **Write accept:** the next cycle has mmio_wr_valid=1, with mmio_address=cmd_addr, mmio_data=cmd_wdata and mmio_tid=0. There is no queue entry and no completion.
- **Read accept:** the next cycle has mmio_rd_valid=1, with mmio_address=cmd_addr, mmio_tid=tid_ctr and mmio_data=0.
  - {tid_ctr, cmd_addr} is pushed into the in-order queue.
  - tid_ctr increments and wraps 511→0.
- mmio_wr_valid and mmio_rd_valid are never asserted together. Each is high for exactly one cycle per accepted command.
- **Response match:** rsp_in_valid with queue non-empty and rsp_in_tid == head tid gives, next cycle, rd_valid=1, rd_addr=head addr, rd_data=rsp_in_data and rd_timeout=0. The head is popped.
- **Response mismatch:** rsp_in_valid with queue empty, or with a tid other than the head tid, sets err_tid. The response is dropped and there is no pop. A late response to a timed-out read lands here.
- **Timeout:**
  - head_timer counts cycles while the queue is non-empty.
  - It clears on every pop and on a push into an empty queue.
  - When head_timer == TIMEOUT-1 and no matching response arrives that cycle, the next cycle has rd_valid=1, rd_timeout=1, rd_data=64'hFFFF_FFFF_FFFF_FFFF and rd_addr=head addr. The head is popped.
- **Simultaneous events:**
  - A matching response beats a timeout in the same cycle.
  - A push and a pop in the same cycle leave outstanding unchanged, and the queue stays consistent.
  - A push into a full queue cannot occur, because cmd_ready=0.
- err_tid clears only on rst.

## Timing
- All outputs are registered except cmd_ready, which is combinational from the outstanding count.
- **Reset values:** all outputs 0 except cmd_ready=1. Internal state: tid_ctr=0, queue empty, head_timer=0, err_tid=0.
- **Reset mid-operation:** the queue, tid_ctr and head_timer are cleared, and no completion is emitted for lost reads. Responses arriving after reset set err_tid.
- **Command latency:** acceptance at edge N puts the request pulse on the outputs for cycle N+1.
- **Completion latency:** a response sampled at edge M puts rd_valid on the outputs for cycle M+1.
- **Back-to-back:** one command per cycle is sustained, for reads until the queue is full.
- **Fastest possible read:** the request is visible at N+1, the AFU responds registered at N+2, and the completion appears at N+3.
- **Timeout timing:** a read that becomes head at edge H with no response completes with rd_timeout on the cycle after edge H+TIMEOUT-1.

## Test plan
- **Write:** accept write addr 16'h0020, wdata 64'hDEAD_BEEF_0123_4567 → the next cycle shows mmio_wr_valid=1, address 16'h0020, that data and tid 0, for exactly one cycle. rd_valid stays 0.
- **Read:** reads of 16'h0000 and 16'h0020 back-to-back against a 1-cycle responder → tids 0 and 1 are issued, and two rd_valid pulses carry addresses 16'h0000 and 16'h0020 in order with the responder's data. outstanding returns to 0.
- **Flow control:** issue 4 reads with MAX_OUTSTANDING=4 and a silent responder → cmd_ready=0 after the 4th accept. Returning one response re-asserts cmd_ready on the cycle after the pop.
- **Timeout:** TIMEOUT=8, one read, no response → rd_valid with rd_timeout=1 and data all ones, 8 cycles after the head push. A later response with that tid sets err_tid and produces no rd_valid.
- **Tid wrap:** issue 513 reads → mmio_tid follows 511, 0, 1, and all completions match with err_tid=0.
- **Reset:** assert rst with 2 reads outstanding → all outputs go to 0, cmd_ready=1, outstanding=0 and the next read uses tid 0.
